// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch side of the Control opcode/state interface:
// state codes, terminal-state membership, instruction field positions and the
// next-PC source selector.
package fetch_sequencer_pkg;

    localparam int unsigned STATE_W    = 4;
    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned JUMP_TGT_W = 26;
    localparam int unsigned IMM_W      = 16;

    // Control state codes (12..15 are illegal)
    localparam logic [3:0] ST_IF      = 4'd0;
    localparam logic [3:0] ST_RF      = 4'd1;
    localparam logic [3:0] ST_IMM2    = 4'd2;
    localparam logic [3:0] ST_ALU_R3  = 4'd3;
    localparam logic [3:0] ST_ALU_RI3 = 4'd4;
    localparam logic [3:0] ST_ALU_4   = 4'd5;
    localparam logic [3:0] ST_BRANCH3 = 4'd6;
    localparam logic [3:0] ST_MEMREF3 = 4'd7;
    localparam logic [3:0] ST_LOAD4   = 4'd8;
    localparam logic [3:0] ST_STORE4  = 4'd9;
    localparam logic [3:0] ST_LOAD5   = 4'd10;
    localparam logic [3:0] ST_JUMP3   = 4'd11;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_SEQ    = 2'd1,
        PC_BRANCH = 2'd2,
        PC_JUMP   = 2'd3
    } pc_sel_t;

    // Leaving one of these states retires the instruction
    function automatic logic is_terminal(input logic [STATE_W-1:0] s);
        return (s == ST_IMM2)    || (s == ST_ALU_4) || (s == ST_BRANCH3) ||
               (s == ST_STORE4)  || (s == ST_LOAD5) || (s == ST_JUMP3);
    endfunction

    function automatic logic is_legal(input logic [STATE_W-1:0] s);
        return s <= ST_JUMP3;
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next_logic.sv
// Combinational next-PC selection (sequential / taken branch / jump / hold)
// and the PC update decision.
//   state      : current Control state code
//   zero       : ALU zero flag, only meaningful in BRANCH3
//   imem_ready : fetch data valid, only meaningful in IF
//   pc         : current PC
//   ir_lo      : IR[25:0] (jump target; low 16 bits are the branch offset)
//   pc_next_c  : PC value to load when pc_update_c is high
//   pc_update_c: PC is written at the next edge
module fetch_sequencer_pc_next_logic
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [STATE_W-1:0]    state,
    input  logic                  zero,
    input  logic                  imem_ready,
    input  logic [ADDR_W-1:0]     pc,
    input  logic [JUMP_TGT_W-1:0] ir_lo,
    output logic [ADDR_W-1:0]     pc_next_c,
    output logic                  pc_update_c
);

    pc_sel_t           pc_sel;
    logic [ADDR_W-1:0] br_off;

    // Word offset, sign-extended then scaled to bytes
    assign br_off = {{(ADDR_W-IMM_W-2){ir_lo[IMM_W-1]}}, ir_lo[IMM_W-1:0], 2'b00};

    // Select the PC source for this state
    always_comb begin
        pc_sel = PC_HOLD;
        case (state)
            ST_IF:      if (imem_ready) pc_sel = PC_SEQ;
            ST_BRANCH3: if (zero)       pc_sel = PC_BRANCH;
            ST_JUMP3:                   pc_sel = PC_JUMP;
            default:                    pc_sel = PC_HOLD;
        endcase
    end

    // Form the next PC; all arithmetic wraps at ADDR_W bits
    always_comb begin
        pc_next_c   = pc;
        pc_update_c = 1'b0;
        case (pc_sel)
            PC_SEQ: begin
                pc_next_c   = pc + ADDR_W'(4);
                pc_update_c = 1'b1;
            end
            PC_BRANCH: begin
                pc_next_c   = pc + br_off;
                pc_update_c = 1'b1;
            end
            PC_JUMP: begin
                pc_next_c   = {pc[ADDR_W-1:28], ir_lo, 2'b00};
                pc_update_c = 1'b1;
            end
            default: begin
                pc_next_c   = pc;
                pc_update_c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns PC and IR, drives the instruction-memory address and
// the opcode seen by Control, counts retired instructions and flags illegal
// Control states.
//   clk, rst_n    : clock, synchronous active-low reset
//   state         : Control state code
//   zero          : ALU zero flag (BRANCH3)
//   imem_rdata    : instruction-memory read data for imem_addr
//   imem_ready    : imem_rdata valid (IF only)
//   imem_addr     : current PC (combinational)
//   opcode        : opcode to Control (combinational)
//   ir            : registered instruction
//   fetch_stall   : Control must hold state (combinational)
//   pc_write      : registered pulse after each PC update
//   instr_count   : saturating retired-instruction count
//   illegal_state : sticky illegal-state flag
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned     ADDR_W   = 32,
    parameter int unsigned     INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [STATE_W-1:0]   state,
    input  logic                 zero,
    input  logic [INSTR_W-1:0]   imem_rdata,
    input  logic                 imem_ready,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [OPCODE_W-1:0]  opcode,
    output logic [INSTR_W-1:0]   ir,
    output logic                 fetch_stall,
    output logic                 pc_write,
    output logic [CNT_W-1:0]     instr_count,
    output logic                 illegal_state
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next_c;
    logic              pc_update_c;
    logic              in_if_c;
    logic              ir_load_c;

    assign in_if_c     = (state == ST_IF);
    assign ir_load_c   = in_if_c && imem_ready;
    assign imem_addr   = pc;
    assign fetch_stall = in_if_c && !imem_ready;

    // Control decodes during IF, so the opcode comes straight from memory then
    assign opcode = in_if_c ? imem_rdata[INSTR_W-1 -: OPCODE_W]
                            : ir[INSTR_W-1 -: OPCODE_W];

    fetch_sequencer_pc_next_logic #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .state       (state),
        .zero        (zero),
        .imem_ready  (imem_ready),
        .pc          (pc),
        .ir_lo       (ir[JUMP_TGT_W-1:0]),
        .pc_next_c   (pc_next_c),
        .pc_update_c (pc_update_c)
    );

    // PC, IR, retire counter and error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            ir            <= '0;
            instr_count   <= '0;
            illegal_state <= 1'b0;
            pc_write      <= 1'b0;
        end else begin
            pc_write <= pc_update_c;
            if (pc_update_c) begin
                pc <= pc_next_c;
            end
            if (ir_load_c) begin
                ir <= imem_rdata;
            end
            if (!is_legal(state)) begin
                illegal_state <= 1'b1;
            end
            if (is_terminal(state) && (instr_count != {CNT_W{1'b1}})) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 4;
    localparam logic [31:0] RP      = 32'h3000_0000;

    localparam logic [31:0] W_ADD  = {6'h01, 26'h0A4_2020};
    localparam logic [31:0] W_J    = {6'h02, 26'h000_0040};
    localparam logic [31:0] W_BEQ  = {6'h04, 10'h000, 16'hFFFE};
    localparam logic [31:0] W_ADDI = {6'h08, 26'h012_3456};
    localparam logic [31:0] W_LD   = {6'h23, 26'h000_0010};
    localparam logic [31:0] W_STR  = {6'h2B, 26'h000_0020};
    localparam logic [31:0] W_LDI  = {6'h0F, 26'h000_00FF};

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         state;
    logic               zero;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ready;
    logic [ADDR_W-1:0]  imem_addr;
    logic [5:0]         opcode;
    logic [INSTR_W-1:0] ir;
    logic               fetch_stall;
    logic               pc_write;
    logic [CNT_W-1:0]   instr_count;
    logic               illegal_state;

    int checks   = 0;
    int failures = 0;

    fetch_sequencer #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (RP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .state         (state),
        .zero          (zero),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .imem_addr     (imem_addr),
        .opcode        (opcode),
        .ir            (ir),
        .fetch_stall   (fetch_stall),
        .pc_write      (pc_write),
        .instr_count   (instr_count),
        .illegal_state (illegal_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch one word with ready high; checks opcode in IF and PC/IR after
    task automatic fetch(input logic [31:0] word, input logic [31:0] exp_pc);
        state      = 4'd0;
        imem_ready = 1'b1;
        imem_rdata = word;
        #1;
        chk("if_opcode", 64'(opcode), 64'(word[31:26]));
        chk("if_no_stall", 64'(fetch_stall), 64'd0);
        tick();
        chk("fetch_ir", 64'(ir), 64'(word));
        chk("fetch_pc", 64'(imem_addr), 64'(exp_pc));
        chk("fetch_pc_write", 64'(pc_write), 64'd1);
    endtask

    // One cycle in a non-IF state, then check the retire count
    task automatic run(input logic [3:0] st, input int exp_cnt);
        state = st;
        tick();
        chk("instr_count", 64'(instr_count), 64'(exp_cnt));
    endtask

    initial begin
        rst_n      = 1'b0;
        state      = 4'd0;
        zero       = 1'b0;
        imem_rdata = '0;
        imem_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_pc", 64'(imem_addr), 64'(RP));
        chk("rst_ir", 64'(ir), 64'd0);
        chk("rst_cnt", 64'(instr_count), 64'd0);
        chk("rst_illegal", 64'(illegal_state), 64'd0);
        chk("rst_pc_write", 64'(pc_write), 64'd0);

        // Stalled IF for three cycles, then the ADD word arrives
        state      = 4'd0;
        imem_rdata = W_ADD;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_flag", 64'(fetch_stall), 64'd1);
            tick();
            chk("stall_pc", 64'(imem_addr), 64'(RP));
            chk("stall_ir", 64'(ir), 64'd0);
            chk("stall_pc_write", 64'(pc_write), 64'd0);
        end
        fetch(W_ADD, RP + 32'h4);

        // ADD: RF, ALU_R3, ALU_4; opcode now from IR; imem_ready ignored
        imem_rdata = W_LDI;
        state      = 4'd1;
        #1;
        chk("rf_opcode_from_ir", 64'(opcode), 64'h01);
        chk("rf_no_stall", 64'(fetch_stall), 64'd0);
        tick();
        chk("rf_pc_hold", 64'(imem_addr), 64'(RP + 32'h4));
        chk("rf_ir_hold", 64'(ir), 64'(W_ADD));
        chk("rf_pc_write_low", 64'(pc_write), 64'd0);
        run(4'd3, 0);
        run(4'd5, 1);

        // JUMP from 0x30000008 to 0x30000100
        fetch(W_J, 32'h3000_0008);
        run(4'd1, 1);
        run(4'd11, 2);
        chk("jump_pc", 64'(imem_addr), 64'h3000_0100);
        chk("jump_pc_write", 64'(pc_write), 64'd1);

        // Taken BEQ with offset -2 words from PC=0x30000104
        fetch(W_BEQ, 32'h3000_0104);
        run(4'd1, 2);
        zero = 1'b1;
        run(4'd6, 3);
        chk("beq_taken_pc", 64'(imem_addr), 64'h3000_00FC);
        chk("beq_taken_pc_write", 64'(pc_write), 64'd1);

        // Not-taken BEQ: PC holds, still retires
        fetch(W_BEQ, 32'h3000_0100);
        zero = 1'b0;
        run(4'd1, 3);
        run(4'd6, 4);
        chk("beq_nt_pc", 64'(imem_addr), 64'h3000_0100);
        chk("beq_nt_pc_write", 64'(pc_write), 64'd0);

        // ADDI
        fetch(W_ADDI, 32'h3000_0104);
        run(4'd1, 4);
        run(4'd4, 4);
        run(4'd5, 5);

        // LD
        fetch(W_LD, 32'h3000_0108);
        run(4'd1, 5);
        run(4'd7, 5);
        run(4'd8, 5);
        run(4'd10, 6);

        // STR
        fetch(W_STR, 32'h3000_010C);
        run(4'd1, 6);
        run(4'd7, 6);
        run(4'd9, 7);

        // LDI: decoded in IF, retires from IMM2
        fetch(W_LDI, 32'h3000_0110);
        run(4'd2, 8);
        chk("seq_pc", 64'(imem_addr), 64'h3000_0110);

        // Counter saturates at 15
        for (int i = 0; i < 8; i++) begin
            fetch(W_LDI, 32'h3000_0114 + 32'(4 * i));
            run(4'd2, (9 + i > 15) ? 15 : 9 + i);
        end
        chk("sat_pc", 64'(imem_addr), 64'h3000_0130);

        // Illegal state: flag set and sticky, everything else holds
        state      = 4'd13;
        imem_ready = 1'b1;
        tick();
        chk("illegal_set", 64'(illegal_state), 64'd1);
        chk("illegal_pc", 64'(imem_addr), 64'h3000_0130);
        chk("illegal_ir", 64'(ir), 64'(W_LDI));
        chk("illegal_cnt", 64'(instr_count), 64'd15);
        chk("illegal_pc_write", 64'(pc_write), 64'd0);
        state      = 4'd1;
        tick();
        chk("illegal_sticky", 64'(illegal_state), 64'd1);

        // Reset during LOAD4: no retire, everything back to reset values
        fetch(W_LD, 32'h3000_0134);
        run(4'd1, 15);
        run(4'd7, 15);
        state = 4'd8;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        state = 4'd1;
        chk("midrst_pc", 64'(imem_addr), 64'(RP));
        chk("midrst_ir", 64'(ir), 64'd0);
        chk("midrst_cnt", 64'(instr_count), 64'd0);
        chk("midrst_illegal", 64'(illegal_state), 64'd0);
        chk("midrst_pc_write", 64'(pc_write), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Opposite end of the Control opcode/state interface: consumes the 4-bit `state` from Control and drives the 6-bit `opcode` that Control decodes.
- Owns the PC and the instruction register (IR) and drives the instruction-memory address.
- Applies the PC updates for sequential fetch, taken branch (BEQ) and jump, and keeps a retired-instruction count plus a sticky illegal-state flag.

Parameters:
- ADDR_W, 32, PC and instruction-memory address width.
- INSTR_W, 32, instruction width; opcode field is IR[INSTR_W-1:INSTR_W-6].
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- state  in  4  current Control state code.
- zero  in  1  ALU zero flag, sampled only in BRANCH3.
- imem_rdata  in  INSTR_W  instruction-memory read data, combinational from imem_addr.
- imem_ready  in  1  imem_rdata valid this cycle.
- imem_addr  out  ADDR_W  equals PC, combinational.
- opcode  out  6  opcode presented to Control.
- ir  out  INSTR_W  registered instruction for datapath field extraction.
- fetch_stall  out  1  Control must hold its state this cycle.
- pc_write  out  1  one-cycle pulse on any PC update.
- instr_count  out  CNT_W  retired-instruction count.
- illegal_state  out  1  sticky error flag.

Behaviour:
- Shared state codes: IF=0, RF=1, IMM2=2, ALU_R3=3, ALU_RI3=4, ALU_4=5, BRANCH3=6, MEMREF3=7, LOAD4=8, STORE4=9, LOAD5=10, JUMP3=11. Codes 12–15 are illegal.
- Reset, on a clock edge with rst_n=0, regardless of state:
  - PC=RESET_PC, IR=0, instr_count=0, illegal_state=0, pc_write=0.
  - No PC or IR update occurs that cycle.
- opcode is combinational:
  - state==IF: imem_rdata[INSTR_W-1:INSTR_W-6], because Control decodes in IF (LDI path).
  - Otherwise: IR[INSTR_W-1:INSTR_W-6].
- fetch_stall = (state==IF) && !imem_ready. It is combinational, with no registered path.
- IF, imem_ready=1: at the edge, IR<=imem_rdata, PC<=PC+4 (mod 2^ADDR_W, wraps silently), pc_write=1.
- IF, imem_ready=0: IR and PC hold, pc_write=0.
- BRANCH3, zero=1:
  - PC<=PC+(sign_extend(IR[15:0])<<2), pc_write=1.
  - PC here is already PC_fetch+4.
  - Arithmetic is ADDR_W-bit with wrap.
- BRANCH3, zero=0: PC holds.
- JUMP3: PC<={PC[ADDR_W-1:28], IR[25:0], 2'b00}, pc_write=1.
- All other legal states: PC and IR hold.
- pc_write is registered: high for exactly the cycle after the updating edge.
- Retire: instr_count increments by 1 at the edge leaving a terminal state (IMM2, ALU_4, BRANCH3, STORE4, LOAD5, JUMP3).
  - Saturates at all-ones.
  - Taken and not-taken branches both retire.
- Illegal state (12–15) sampled at an edge:
  - illegal_state<=1, held until reset.
  - PC, IR and instr_count hold.
- Reset mid-instruction (e.g. in LOAD4): next cycle outputs are the reset values. The instruction does not retire.
- imem_ready is ignored outside IF.

Decomposition:
- Shared package/include `ctrl_states.v`, consumed by both Control and fetch_sequencer:
  - the 12 state-code localparams;
  - terminal-state membership;
  - opcode field slice positions.
- Opcode values stay in the existing `opcodes.v`.
- One natural sub-module, `pc_next_logic`: combinational next-PC selection (seq / branch / jump / hold) and the pc_write decision.
- Registers and counters stay in the top module.

Test Plan:
- Reset then IF with imem_rdata=ADD word, ready=1 -> opcode=OP.ADD during IF; after the edge IR=word, PC=0x4, pc_write=1 next cycle.
- IF with imem_ready=0 for 3 cycles, then 1 -> fetch_stall=1 for 3 cycles; PC stays 0x0 until the ready edge, then becomes 0x4.
- PC=0x104 in BRANCH3, IR[15:0]=0xFFFE:
  - zero=1 -> PC=0xFC;
  - repeat with zero=0 -> PC stays 0x104;
  - instr_count increments in both cases.
- PC=0x30000008, JUMP3, IR[25:0]=0x0000040 -> PC=0x30000100.
- Run the ADD, ADDI, BEQ, LD, STR, JUMP, LDI state sequences -> instr_count=7 at the end; no increment in non-terminal states.
- Drive state=13 for one cycle -> illegal_state=1 and held; PC unchanged.
- Reset asserted during LOAD4 -> PC=RESET_PC, IR=0, instr_count=0 next cycle.
